// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_access_ctrl
//  Brief    : Load/store sequencer for a single-port word-addressed data
//             memory; byte stores are done as read-modify-write.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int MEM_AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_rnw
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_RWAIT = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_write;
    logic                r_byte;
    logic [1:0]          r_lane;
    logic [MEM_AW-1:0]   r_waddr;
    logic [31:0]         r_wbuf;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;

    logic                w_accept;
    logic                w_err;
    logic [7:0]          w_rbyte;
    logic [31:0]         w_merged;

    assign w_accept = req_valid && req_ready;
    assign w_err    = (!req_byte && (req_addr[1:0] != 2'b00))
                    || ((req_addr >> (MEM_AW + 2)) != 32'd0);

    // Byte lane extraction and merge, little-endian lane order
    always_comb begin
        w_rbyte  = mem_rdata[7:0];
        w_merged = mem_rdata;
        case (r_lane)
            2'd0: begin w_rbyte = mem_rdata[7:0];   w_merged[7:0]   = r_wbuf[7:0]; end
            2'd1: begin w_rbyte = mem_rdata[15:8];  w_merged[15:8]  = r_wbuf[7:0]; end
            2'd2: begin w_rbyte = mem_rdata[23:16]; w_merged[23:16] = r_wbuf[7:0]; end
            default: begin w_rbyte = mem_rdata[31:24]; w_merged[31:24] = r_wbuf[7:0]; end
        endcase
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = (r_state == S_IDLE) && !reset;
        resp_valid = (r_state == S_RESP) && !reset;
        mem_en     = 1'b0;
        mem_rnw    = 1'b1;
        mem_wdata  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err)
                        w_next = S_RESP;
                    else if (req_write && !req_byte)
                        w_next = S_WRITE;
                    else
                        w_next = S_READ;
                end
            end
            S_READ: begin
                mem_en = !reset;
                w_next = S_RWAIT;
            end
            S_RWAIT: begin
                w_next = r_write ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                // A write pending while reset is high must never reach memory
                if (!reset) begin
                    mem_en    = 1'b1;
                    mem_rnw   = 1'b0;
                    mem_wdata = r_wbuf;
                end
                w_next = S_RESP;
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_byte       <= 1'b0;
            r_lane       <= 2'd0;
            r_waddr      <= '0;
            r_wbuf       <= 32'd0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= req_write;
                r_byte  <= req_byte;
                r_lane  <= req_addr[1:0];
                r_waddr <= req_addr[MEM_AW+1:2];
                r_wbuf  <= req_wdata;
                if (w_err) begin
                    r_resp_rdata <= 32'd0;
                    r_resp_err   <= 1'b1;
                end
            end
            if (r_state == S_RWAIT) begin
                if (r_write) begin
                    r_wbuf <= w_merged;
                end else begin
                    r_resp_rdata <= r_byte ? {24'd0, w_rbyte} : mem_rdata;
                    r_resp_err   <= 1'b0;
                end
            end
            if (r_state == S_WRITE) begin
                r_resp_rdata <= 32'd0;
                r_resp_err   <= 1'b0;
            end
        end
    end

    assign mem_addr   = {{(32 - MEM_AW){1'b0}}, r_waddr};
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_access_ctrl
//  Brief    : Directed vector bench for dmem_access_ctrl with a memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_en;
    logic        mem_rnw;

    logic [31:0] mem [256] = '{default: 32'h0};
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    dmem_access_ctrl #(.MEM_AW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_en     (mem_en),
        .mem_rnw    (mem_rnw)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: read data valid the cycle after the enable edge
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rnw) begin
                mem_rdata <= mem[mem_addr[7:0]];
            end else begin
                mem[mem_addr[7:0]] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    typedef struct {
        logic        wr;
        logic        by;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_acc;
        logic        hold;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input logic by, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_lat, input int exp_acc,
                                input logic hold);
        vec_t v;
        v.wr = wr; v.by = by; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_acc = exp_acc; v.hold = hold;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v, input string tag);
        int          guard = 0;
        int          lat = 0;
        int          acc = 0;
        logic        got = 1'b0;
        logic        busy_ready = 1'b0;
        logic [31:0] rd = 32'd0;
        logic        er = 1'b0;
        @(negedge clk);
        req_write = v.wr;
        req_byte  = v.by;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            chk({tag, " accept_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!v.hold) req_valid = 1'b0;
        for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            if (mem_en) acc++;
            if (req_ready) busy_ready = 1'b1;
            if (resp_valid) begin
                got = 1'b1;
                lat = k;
                rd  = resp_rdata;
                er  = resp_err;
            end
        end
        req_valid = 1'b0;
        chk({tag, " latency"},    32'(lat), 32'(v.exp_lat));
        chk({tag, " rdata"},      rd, v.exp_rdata);
        chk({tag, " err"},        32'(er), 32'(v.exp_err));
        chk({tag, " mem_access"}, 32'(acc), 32'(v.exp_acc));
        chk({tag, " ready_busy"}, 32'(busy_ready), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"},  32'(req_ready), 32'd1);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, " resp_err"},   32'(resp_err), 32'd0);
        chk({tag, " mem_en"},     32'(mem_en), 32'd0);
        chk({tag, " mem_rnw"},    32'(mem_rnw), 32'd1);
        chk({tag, " mem_wdata"},  mem_wdata, 32'd0);
        chk({tag, " mem_addr"},   mem_addr, 32'd0);
    endtask

    // Byte store to word 4 aborted by reset in cycle rc (2 = RWAIT, 3 = WRITE)
    task automatic rst_mid(input int rc, input string tag);
        int          w0 = wr_cnt;
        logic [31:0] m0 = mem[4];
        int          rv = 0;
        int          guard = 0;
        @(negedge clk);
        req_write = 1'b1; req_byte = 1'b1; req_addr = 32'h11; req_wdata = 32'h77;
        req_valid = 1'b1;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= rc; k++) begin
            @(negedge clk);
            if (resp_valid) rv++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs(tag);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) rv++;
        end
        chk({tag, " no_resp"},  32'(rv), 32'd0);
        chk({tag, " no_write"}, 32'(wr_cnt - w0), 32'd0);
        chk({tag, " word4"},    mem[4], m0);
    endtask

    initial begin
        // Rows: wr, byte, addr, wdata, exp_rdata, exp_err, latency, accesses, hold
        vecs.push_back(mk(1, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 3, 1, 0));
        vecs.push_back(mk(1, 1, 32'h12,  32'h0000005A, 32'h0,        0, 4, 2, 0));
        vecs.push_back(mk(0, 0, 32'h10,  32'h0,        32'hDE5ABEEF, 0, 3, 1, 0));
        vecs.push_back(mk(0, 1, 32'h12,  32'h0,        32'h0000005A, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 32'h13,  32'h0,        32'h0,        1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h400, 32'h12345678, 32'h0,        1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,        32'h0,        0, 3, 1, 0));
        vecs.push_back(mk(0, 1, 32'h13,  32'h0,        32'h000000DE, 0, 3, 1, 1));
        vecs.push_back(mk(0, 1, 32'h10,  32'h0,        32'h000000EF, 0, 3, 1, 0));
        vecs.push_back(mk(0, 1, 32'h800, 32'h0,        32'h0,        1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h20,  32'hFFFFFFFF, 32'h0,        0, 2, 1, 0));
        vecs.push_back(mk(1, 0, 32'h20,  32'h0,        32'h0,        0, 2, 1, 0));
        vecs.push_back(mk(1, 1, 32'h20,  32'hAAAAAA11, 32'h0,        0, 4, 2, 0));
        vecs.push_back(mk(1, 1, 32'h21,  32'hBBBBBB22, 32'h0,        0, 4, 2, 1));
        vecs.push_back(mk(1, 1, 32'h22,  32'hCCCCCC33, 32'h0,        0, 4, 2, 0));
        vecs.push_back(mk(1, 1, 32'h23,  32'hDDDDDD44, 32'h0,        0, 4, 2, 0));
        vecs.push_back(mk(0, 0, 32'h20,  32'h0,        32'h44332211, 0, 3, 1, 0));
        vecs.push_back(mk(1, 0, 32'h3FC, 32'hCAFEF00D, 32'h0,        0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 32'h3FC, 32'h0,        32'hCAFEF00D, 0, 3, 1, 0));
        vecs.push_back(mk(1, 1, 32'h3FE, 32'h000000A5, 32'h0,        0, 4, 2, 0));

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("por");

        foreach (vecs[i]) do_req(vecs[i], $sformatf("vec%0d", i));

        chk("mem_word4",   mem[4],   32'hDE5ABEEF);
        chk("mem_word0",   mem[0],   32'h0);
        chk("mem_word8",   mem[8],   32'h44332211);
        chk("mem_word255", mem[255], 32'hCAA5F00D);

        do_req(mk(0, 1, 32'h12, 32'h0, 32'h5A, 0, 3, 1, 0), "pre_rst_a");
        rst_mid(2, "rst_rwait");
        do_req(mk(0, 1, 32'h12, 32'h0, 32'h5A, 0, 3, 1, 0), "pre_rst_b");
        rst_mid(3, "rst_write");
        do_req(mk(0, 0, 32'h10, 32'h0, 32'hDE5ABEEF, 0, 3, 1, 0), "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
